// File: rtl/soc_ar_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ariane_soc / soc_ar_scheduler_pkg
// Description : ariane_soc holds the shared SoC memory map, slave enumeration
//               and AXI ID widths. soc_ar_scheduler_pkg holds the scheduler
//               FSM state type and the address-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ariane_soc;

    localparam int unsigned IdWidth      = 4;
    localparam int unsigned IdWidthSlave = 5;
    localparam int unsigned NrSlaves     = 5;

    typedef enum logic [2:0] {
        DRAM  = 3'd0,
        ExtIO = 3'd1,
        PLIC  = 3'd2,
        CLINT = 3'd3,
        Debug = 3'd4
    } axi_slaves_t;

    localparam logic [63:0] DebugBase   = 64'h0000_0000;
    localparam logic [63:0] DebugLength = 64'h0000_1000;
    localparam logic [63:0] CLINTBase   = 64'h0200_0000;
    localparam logic [63:0] CLINTLength = 64'h000C_0000;
    localparam logic [63:0] PLICBase    = 64'h0C00_0000;
    localparam logic [63:0] PLICLength  = 64'h03FF_FFFF;
    localparam logic [63:0] ExtIOBase   = 64'h4000_0000;
    localparam logic [63:0] ExtIOLength = 64'h1000_0000;
    localparam logic [63:0] DRAMBase    = 64'h8000_0000;
    localparam logic [63:0] DRAMLength  = 64'h4000_0000;

endpackage

package soc_ar_scheduler_pkg;

    import ariane_soc::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ERR  = 2'd2
    } sched_state_e;

    // One-hot slave select for an address; all-zero means decode miss.
    function automatic logic [NrSlaves-1:0] addr_decode(input logic [63:0] addr);
        logic [NrSlaves-1:0] sel;
        sel = '0;
        if (addr >= DRAMBase  && addr < DRAMBase  + DRAMLength)  sel[DRAM]  = 1'b1;
        if (addr >= ExtIOBase && addr < ExtIOBase + ExtIOLength) sel[ExtIO] = 1'b1;
        if (addr >= PLICBase  && addr < PLICBase  + PLICLength)  sel[PLIC]  = 1'b1;
        if (addr >= CLINTBase && addr < CLINTBase + CLINTLength) sel[CLINT] = 1'b1;
        if (addr >= DebugBase && addr < DebugBase + DebugLength) sel[Debug] = 1'b1;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_ar_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_ctrl
// Description : Round-robin arbiter. Searches the eligibility vector starting
//               at the pointer, returns a one-hot grant plus its index, and
//               moves the pointer just past the winner when accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_ctrl #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              accept_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    logic [IdxW-1:0] r_ptr_q;
    logic [IdxW-1:0] w_ptr_d;
    logic [IdxW-1:0] w_idx;
    logic [IdxW-1:0] w_gnt_idx;
    logic            w_found;

    // First eligible requester at or after the pointer wins.
    always_comb begin
        gnt_o     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            w_idx = IdxW'((32'(r_ptr_q) + k) % NumReq);
            if (!w_found && req_i[w_idx]) begin
                w_found      = 1'b1;
                w_gnt_idx    = w_idx;
                gnt_o[w_idx] = 1'b1;
            end
        end
    end

    assign gnt_idx_o = w_gnt_idx;

    // Pointer advances to the requester after the accepted winner.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (accept_i && w_found) begin
            if (32'(w_gnt_idx) == NumReq - 1) begin
                w_ptr_d = '0;
            end else begin
                w_ptr_d = w_gnt_idx + 1'b1;
            end
        end
    end

    // Pointer register; master 0 has priority after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/soc_ar_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : soc_ar_scheduler
// Description : AXI read-address scheduler. Arbitrates the masters'
//               read-address requests round-robin, decodes the address
//               against the SoC map and forwards to one slave or to the
//               decode-error responder. Tracks per-master outstanding reads
//               and stops granting a master at MaxOutstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_ar_scheduler
    import ariane_soc::*;
    import soc_ar_scheduler_pkg::*;
#(
    parameter  int unsigned NrMasters      = 2,
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrMasters-1:0]                req_valid_i,
    output logic [NrMasters-1:0]                req_ready_o,
    input  logic [NrMasters-1:0][63:0]          req_addr_i,
    input  logic [NrMasters-1:0][IdWidth-1:0]   req_id_i,
    output logic [NrSlaves-1:0]                 slv_valid_o,
    input  logic [NrSlaves-1:0]                 slv_ready_i,
    output logic [63:0]                         slv_addr_o,
    output logic [IdWidthSlave-1:0]             slv_id_o,
    output logic                                err_valid_o,
    input  logic                                err_ready_i,
    output logic [IdWidthSlave-1:0]             err_id_o,
    input  logic                                done_valid_i,
    input  logic [IdWidthSlave-1:0]             done_id_i,
    output logic [NrMasters-1:0][CntWidth-1:0]  outstanding_o
);

    localparam int unsigned MstIdxW = IdWidthSlave - IdWidth;
    localparam int unsigned GntIdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;

    sched_state_e                       r_state_q, w_state_d;
    logic [NrSlaves-1:0]                r_slv_sel_q, w_slv_sel_d;
    logic [63:0]                        r_addr_q, w_addr_d;
    logic [IdWidthSlave-1:0]            r_slv_id_q, w_slv_id_d;
    logic [IdWidthSlave-1:0]            r_err_id_q, w_err_id_d;
    logic [NrMasters-1:0][CntWidth-1:0] r_cnt_q, w_cnt_d;

    logic [NrMasters-1:0]    w_eligible;
    logic [NrMasters-1:0]    w_gnt;
    logic [GntIdxW-1:0]      w_gnt_idx;
    logic                    w_accept;
    logic [63:0]             w_grant_addr;
    logic [IdWidthSlave-1:0] w_grant_id;
    logic [NrSlaves-1:0]     w_grant_sel;
    logic [MstIdxW-1:0]      w_done_idx;
    logic [NrMasters-1:0]    w_inc;
    logic [NrMasters-1:0]    w_dec;
    logic                    w_unused_done_id;

    // The low done_id bits carry the master's own ID and play no part here.
    assign w_unused_done_id = ^done_id_i[IdWidth-1:0];
    assign w_done_idx       = done_id_i[IdWidthSlave-1:IdWidth];

    // A master competes only while below its outstanding limit.
    always_comb begin
        w_eligible = '0;
        for (int unsigned m = 0; m < NrMasters; m++) begin
            w_eligible[m] = req_valid_i[m] && (r_cnt_q[m] < CntWidth'(MaxOutstanding));
        end
    end

    rr_arb_ctrl #(
        .NumReq    (NrMasters)
    ) u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (w_eligible),
        .accept_i  (w_accept),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    assign w_grant_addr = req_addr_i[w_gnt_idx];
    assign w_grant_id   = {MstIdxW'(w_gnt_idx), req_id_i[w_gnt_idx]};
    assign w_grant_sel  = addr_decode(w_grant_addr);

    // Next-state and capture logic; ready is only offered from IDLE.
    always_comb begin
        w_state_d   = r_state_q;
        w_slv_sel_d = r_slv_sel_q;
        w_addr_d    = r_addr_q;
        w_slv_id_d  = r_slv_id_q;
        w_err_id_d  = r_err_id_q;
        w_accept    = 1'b0;
        req_ready_o = '0;
        case (r_state_q)
            IDLE: begin
                if (|w_eligible) begin
                    w_accept    = 1'b1;
                    req_ready_o = w_gnt;
                    if (|w_grant_sel) begin
                        w_state_d   = FWD;
                        w_slv_sel_d = w_grant_sel;
                        w_addr_d    = w_grant_addr;
                        w_slv_id_d  = w_grant_id;
                    end else begin
                        w_state_d   = ERR;
                        w_err_id_d  = w_grant_id;
                    end
                end
            end
            FWD: begin
                if (|(r_slv_sel_q & slv_ready_i)) begin
                    w_state_d = IDLE;
                end
            end
            ERR: begin
                if (err_ready_i) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Outstanding counters: +1 on grant, -1 on done, never below zero.
    always_comb begin
        w_inc   = '0;
        w_dec   = '0;
        w_cnt_d = r_cnt_q;
        for (int unsigned m = 0; m < NrMasters; m++) begin
            w_inc[m]   = req_valid_i[m] & req_ready_o[m];
            w_dec[m]   = done_valid_i && (32'(w_done_idx) == m) && (r_cnt_q[m] != '0);
            w_cnt_d[m] = r_cnt_q[m] + CntWidth'(w_inc[m]) - CntWidth'(w_dec[m]);
        end
    end

    // State, captured request and counters; reset drops any pending transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q   <= IDLE;
            r_slv_sel_q <= '0;
            r_addr_q    <= '0;
            r_slv_id_q  <= '0;
            r_err_id_q  <= '0;
            r_cnt_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_slv_sel_q <= w_slv_sel_d;
            r_addr_q    <= w_addr_d;
            r_slv_id_q  <= w_slv_id_d;
            r_err_id_q  <= w_err_id_d;
            r_cnt_q     <= w_cnt_d;
        end
    end

    assign slv_valid_o   = (r_state_q == FWD) ? r_slv_sel_q : '0;
    assign slv_addr_o    = r_addr_q;
    assign slv_id_o      = r_slv_id_q;
    assign err_valid_o   = (r_state_q == ERR);
    assign err_id_o      = r_err_id_q;
    assign outstanding_o = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_ar_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_soc_ar_scheduler
// Description : Self-checking bench for soc_ar_scheduler: decode table,
//               directed multi-cycle sequences and randomized traffic against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_ar_scheduler;

    localparam int NM   = 2;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NM-1:0]          req_valid, req_ready;
    logic [NM-1:0][63:0]    req_addr;
    logic [NM-1:0][3:0]     req_id;
    logic [4:0]             slv_valid, slv_ready;
    logic [63:0]            slv_addr;
    logic [4:0]             slv_id;
    logic                   err_valid, err_ready;
    logic [4:0]             err_id;
    logic                   done_valid;
    logic [4:0]             done_id;
    logic [NM-1:0][CW-1:0]  outstanding;

    always #5 clk = ~clk;

    soc_ar_scheduler #(
        .NrMasters      (NM),
        .MaxOutstanding (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_id_i      (req_id),
        .slv_valid_o   (slv_valid),
        .slv_ready_i   (slv_ready),
        .slv_addr_o    (slv_addr),
        .slv_id_o      (slv_id),
        .err_valid_o   (err_valid),
        .err_ready_i   (err_ready),
        .err_id_o      (err_id),
        .done_valid_i  (done_valid),
        .done_id_i     (done_id),
        .outstanding_o (outstanding)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_cnt [NM];
    int          m_rr;
    bit          m_pend;
    bit          m_pend_err;
    int          m_pend_slv;
    logic [63:0] m_addr;
    logic [4:0]  m_slv_id;
    logic [4:0]  m_err_id;
    int          m_gnt;

    // Memory map written straight from the address windows; -1 = miss.
    function automatic int ref_decode(input logic [63:0] a);
        longint unsigned base [5] = '{64'h8000_0000, 64'h4000_0000, 64'h0C00_0000,
                                      64'h0200_0000, 64'h0000_0000};
        longint unsigned len  [5] = '{64'h4000_0000, 64'h1000_0000, 64'h03FF_FFFF,
                                      64'h000C_0000, 64'h0000_1000};
        for (int s = 0; s < 5; s++) begin
            if (a >= base[s] && a < base[s] + len[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NM; m++) m_cnt[m] = 0;
        m_rr = 0; m_pend = 0; m_pend_err = 0; m_pend_slv = 0;
        m_addr = '0; m_slv_id = '0; m_err_id = '0; m_gnt = -1;
    endtask

    task automatic model_check();
        m_gnt = -1;
        if (!m_pend) begin
            for (int k = 0; k < NM; k++) begin
                int m;
                m = (m_rr + k) % NM;
                if (m_gnt < 0 && req_valid[m] && m_cnt[m] < MAXO) m_gnt = m;
            end
        end
        chk("req_ready", req_ready, (m_gnt >= 0) ? (64'd1 << m_gnt) : 64'd0);
        chk("slv_valid", slv_valid, (m_pend && !m_pend_err) ? (64'd1 << m_pend_slv) : 64'd0);
        chk("slv_addr", slv_addr, m_addr);
        chk("slv_id", slv_id, m_slv_id);
        chk("err_valid", err_valid, m_pend && m_pend_err);
        chk("err_id", err_id, m_err_id);
        for (int m = 0; m < NM; m++) chk($sformatf("outstanding%0d", m), outstanding[m], m_cnt[m]);
    endtask

    task automatic model_update();
        int di;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_pend && (m_pend_err ? err_ready : slv_ready[m_pend_slv])) m_pend = 0;
        di = int'(done_id[4]);
        if (done_valid && di < NM && m_cnt[di] > 0) m_cnt[di]--;
        if (m_gnt >= 0) begin
            m_cnt[m_gnt]++;
            s = ref_decode(req_addr[m_gnt]);
            m_pend = 1;
            if (s < 0) begin
                m_pend_err = 1;
                m_err_id   = {m_gnt[0], req_id[m_gnt]};
            end else begin
                m_pend_err = 0;
                m_pend_slv = s;
                m_addr     = req_addr[m_gnt];
                m_slv_id   = {m_gnt[0], req_id[m_gnt]};
            end
            m_rr = (m_gnt + 1) % NM;
        end
    endtask

    // One clock: inputs already driven at negedge; check, clock, update model.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst        = 1'b0;
        req_valid  = '0;
        done_valid = 1'b0;
        done_id    = '0;
        slv_ready  = 5'h1f;
        err_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int          mst;
        logic [63:0] addr;
        logic [3:0]  id;
        logic [4:0]  exp_slv;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] hold_addr;

        vecs[0] = '{0, 64'h0000_0000_8000_0040, 4'h3, 5'b00001, 1'b0};
        vecs[1] = '{1, 64'h0000_0000_3000_0000, 4'hA, 5'b00000, 1'b1};
        vecs[2] = '{0, 64'h0000_0000_0FFF_FFFE, 4'h1, 5'b00100, 1'b0};
        vecs[3] = '{0, 64'h0000_0000_0FFF_FFFF, 4'h2, 5'b00000, 1'b1};
        vecs[4] = '{1, 64'h0000_0000_BFFF_FFFF, 4'h7, 5'b00001, 1'b0};
        vecs[5] = '{0, 64'h0000_0000_C000_0000, 4'h4, 5'b00000, 1'b1};
        vecs[6] = '{1, 64'h0000_0000_0000_0FFF, 4'h5, 5'b10000, 1'b0};
        vecs[7] = '{0, 64'h0000_0000_0200_0000, 4'hF, 5'b01000, 1'b0};
        vecs[8] = '{1, 64'h0000_0000_020C_0000, 4'h6, 5'b00000, 1'b1};
        vecs[9] = '{0, 64'h0000_0000_4FFF_FFFF, 4'h9, 5'b00010, 1'b0};

        idle_inputs();
        req_addr = '0;
        req_id   = '0;
        rst      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Decode table: single request, check grant, routing, ID and count.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            req_valid[vecs[i].mst] = 1'b1;
            req_addr[vecs[i].mst]  = vecs[i].addr;
            req_id[vecs[i].mst]    = vecs[i].id;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, 64'd1 << vecs[i].mst);
            tick();
            req_valid = '0;
            #1;
            chk($sformatf("vec%0d_slv_valid", i), slv_valid, vecs[i].exp_slv);
            chk($sformatf("vec%0d_err_valid", i), err_valid, vecs[i].exp_err);
            if (vecs[i].exp_err)
                chk($sformatf("vec%0d_err_id", i), err_id, {vecs[i].mst[0], vecs[i].id});
            else
                chk($sformatf("vec%0d_slv_id", i), slv_id, {vecs[i].mst[0], vecs[i].id});
            tick();
            #1;
            chk($sformatf("vec%0d_outstanding", i), outstanding[vecs[i].mst], 1);
            tick();
        end

        // First directed request: DRAM, ID 0x03 on master 0.
        do_reset();
        req_valid[0] = 1'b1; req_addr[0] = 64'h8000_0040; req_id[0] = 4'h3;
        tick();
        req_valid = '0;
        #1;
        chk("m0_dram_slv_id", slv_id, 5'h03);
        chk("m0_dram_outstanding", outstanding[0], 1);
        tick();

        // Both masters hammering: grants alternate every other cycle.
        do_reset();
        req_valid = 2'b11;
        req_addr[0] = 64'h8000_0100; req_id[0] = 4'h1;
        req_addr[1] = 64'h8000_0200; req_id[1] = 4'h2;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("alt_ready_c%0d", c), req_ready,
                (c % 2 != 0) ? 64'd0 : (((c / 2) % 2 != 0) ? 64'd2 : 64'd1));
            tick();
        end

        // Outstanding limit: fifth M0 request stalls until a done arrives.
        do_reset();
        req_valid = 2'b01;
        req_addr[0] = 64'h8000_0000; req_id[0] = 4'h0;
        req_addr[1] = 64'h8000_1000; req_id[1] = 4'h8;
        for (int c = 0; c < 8; c++) tick();
        req_valid = 2'b11;
        #1;
        chk("limit_m0_count", outstanding[0], 4);
        chk("limit_m1_granted", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        tick();
        done_valid = 1'b1; done_id = 5'h00;
        #1;
        chk("limit_m0_stalled", req_ready, 2'b00);
        tick();
        done_valid = 1'b0;
        #1;
        chk("limit_m0_fifth_accepted", req_ready, 2'b01);
        chk("limit_m0_count_after_done", outstanding[0], 3);
        tick();

        // Stalled slave then reset: transaction dropped, everything cleared.
        do_reset();
        req_valid[0] = 1'b1; req_addr[0] = 64'h8000_1000; req_id[0] = 4'hC;
        slv_ready = 5'h00;
        tick();
        req_valid = '0;
        hold_addr = 64'h8000_1000;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("stall_valid_c%0d", c), slv_valid, 5'b00001);
            chk($sformatf("stall_addr_c%0d", c), slv_addr, hold_addr);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_slv_valid", slv_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_slv_addr", slv_addr, 0);
        chk("rst_slv_id", slv_id, 0);
        chk("rst_err_id", err_id, 0);
        chk("rst_outstanding0", outstanding[0], 0);
        chk("rst_outstanding1", outstanding[1], 0);
        req_valid[1] = 1'b1; req_addr[1] = 64'h4000_0000;
        #1;
        chk("rst_idle_grants", req_ready, 2'b10);
        tick();
        idle_inputs();
        tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NM; m++) begin
                req_valid[m] = ($urandom_range(0, 2) != 0);
                req_id[m]    = 4'($urandom);
                case ($urandom_range(0, 5))
                    0: req_addr[m] = 64'h8000_0000 + 64'($urandom_range(0, 32'h3FFF_FFFF));
                    1: req_addr[m] = 64'h4000_0000 + 64'($urandom_range(0, 32'h0FFF_FFFF));
                    2: req_addr[m] = 64'h0C00_0000 + 64'($urandom_range(32'h03FF_FFF0, 32'h03FF_FFFF));
                    3: req_addr[m] = {32'($urandom), 32'($urandom)};
                    4: req_addr[m] = 64'($urandom_range(0, 32'h1FFF));
                    default: req_addr[m] = 64'h0200_0000 + 64'($urandom_range(32'hBFFF0, 32'hC0010));
                endcase
            end
            slv_ready  = 5'($urandom);
            err_ready  = ($urandom_range(0, 1) != 0);
            done_valid = ($urandom_range(0, 2) == 0);
            done_id    = 5'($urandom);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
